// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg: shared widths, sample/FSM types and ADC code conversion
package adc_cond_pkg;
  localparam int ADC_W  = 14;
  localparam int OUT_W  = 16;
  localparam int DROP_W = 16;
  typedef logic signed [ADC_W-1:0] adc_s_t;
  typedef enum logic {DISABLED, ACCUM} fsm_t;
  // inv=1: flip magnitude bits; inv=0: offset binary, flip the MSB
  function automatic adc_s_t conv_code(input logic [ADC_W-1:0] raw, input logic inv);
    return inv ? {raw[ADC_W-1], ~raw[ADC_W-2:0]} : raw ^ {1'b1, {(ADC_W-1){1'b0}}};
  endfunction
endpackage

// File: rtl/adc_cond_fmt.sv
// adc_cond_fmt: stage-1 input register and code conversion; ADC_COND_OFFSET_EN adds offset subtract with saturation
module adc_cond_fmt import adc_cond_pkg::*; #(
  parameter bit ADC_INV = 1'b1
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  input  logic [ADC_W-1:0] adc_dat_i,
  input  logic             adc_vld_i,
`ifdef ADC_COND_OFFSET_EN
  input  logic [ADC_W-1:0] offset_i,
`endif
  output adc_s_t           s14_o,
  output logic             vld_o
);
  logic [ADC_W-1:0] dat_q;
  logic             vld_q;
  adc_s_t           conv;
  // register raw code and strobe together
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i)
    if (!adc_rstn_i) begin
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      dat_q <= adc_dat_i;
      vld_q <= adc_vld_i;
    end
  assign conv  = conv_code(dat_q, ADC_INV);
  assign vld_o = vld_q;
`ifdef ADC_COND_OFFSET_EN
  // one extra bit of headroom; sign bits disagreeing means out of s14 range
  logic signed [ADC_W:0] diff;
  assign diff  = $signed({conv[ADC_W-1], conv}) - $signed({offset_i[ADC_W-1], offset_i});
  assign s14_o = (diff[ADC_W] == diff[ADC_W-1]) ? diff[ADC_W-1:0] :
                 diff[ADC_W] ? {1'b1, {(ADC_W-1){1'b0}}} : {1'b0, {(ADC_W-1){1'b1}}};
`else
  assign s14_o = conv;
`endif
endmodule

// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: ADC qualify/convert, boxcar decimate by 2^DEC_LOG2, valid/ready output with drop tracking (ADC_COND_OFFSET_EN adds offset_i)
module adc_sample_conditioner import adc_cond_pkg::*; #(
  parameter int DEC_LOG2 = 2,
  parameter bit ADC_INV  = 1'b1
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic              en_i,
  input  logic [ADC_W-1:0]  adc_dat_i,
  input  logic              adc_vld_i,
`ifdef ADC_COND_OFFSET_EN
  input  logic [ADC_W-1:0]  offset_i,
`endif
  output logic [OUT_W-1:0]  m_dat_o,
  output logic              m_vld_o,
  input  logic              m_rdy_i,
  output logic              ovr_o,
  input  logic              ovr_clr_i,
  output logic [DROP_W-1:0] drop_cnt_o
);
  localparam int AW = ADC_W + DEC_LOG2;
  localparam int CW = DEC_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** DEC_LOG2) - 1);
  localparam logic signed [AW-1:0] RND = AW'((2 ** DEC_LOG2) >> 1);
  adc_s_t                 s14, mean;
  logic                   s_vld, acc_en, done, load, drop;
  fsm_t                   state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d, sum, rnd_sum;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUT_W-1:0]       m_dat_q, m_dat_d;
  logic                   m_vld_q, m_vld_d, ovr_q, ovr_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  adc_cond_fmt #(.ADC_INV(ADC_INV)) u_fmt (
    .adc_clk_i (adc_clk_i),
    .adc_rstn_i(adc_rstn_i),
    .adc_dat_i (adc_dat_i),
    .adc_vld_i (adc_vld_i),
`ifdef ADC_COND_OFFSET_EN
    .offset_i  (offset_i),
`endif
    .s14_o     (s14),
    .vld_o     (s_vld)
  );
  // FSM state register
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i)
    if (!adc_rstn_i) state_q <= DISABLED;
    else state_q <= state_d;
  // FSM next state: follow en_i one cycle later
  always_comb state_d = en_i ? ACCUM : DISABLED;
  // FSM output: accumulate only while enabled in ACCUM
  always_comb acc_en = (state_q == ACCUM) && en_i;
  // block sum fits in AW bits even with the rounding term added
  assign sum     = acc_q + AW'(s14);
  assign rnd_sum = sum + RND;
  assign mean    = adc_s_t'(rnd_sum >>> DEC_LOG2);
  assign done    = acc_en && s_vld && (cnt_q == CNT_LAST);
  assign load    = done && (!m_vld_q || m_rdy_i);
  assign drop    = done && m_vld_q && !m_rdy_i;
  // accumulator, output register and drop tracking next state
  always_comb begin
    acc_d   = !acc_en ? '0 : !s_vld ? acc_q : done ? '0 : sum;
    cnt_d   = !acc_en ? '0 : !s_vld ? cnt_q : done ? '0 : cnt_q + 1'b1;
    m_dat_d = load ? {mean, 2'b00} : m_dat_q;
    m_vld_d = load || (m_vld_q && !m_rdy_i);
    ovr_d   = drop || (ovr_q && !ovr_clr_i);
    drop_d  = ovr_clr_i ? DROP_W'(drop) : drop_q + DROP_W'(drop && !(&drop_q));
  end
  // datapath registers
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i)
    if (!adc_rstn_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      m_dat_q <= '0;
      m_vld_q <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      m_dat_q <= m_dat_d;
      m_vld_q <= m_vld_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  assign m_dat_o    = m_dat_q;
  assign m_vld_o    = m_vld_q;
  assign ovr_o      = ovr_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_adc_sample_conditioner.sv
// tb_adc_sample_conditioner: directed vector checks of pass-through and decimating conditioner instances
module tb_adc_sample_conditioner;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, ovr_clr = 1'b0;
  logic [13:0] p_dat = '0, dat = '0, off = '0;
  logic p_vld = 1'b0, p_rdy = 1'b1, vld = 1'b0, rdy = 1'b1;
  logic [15:0] d0, d1, d2, c0, c1, c2;
  logic v0, v1, v2, o0, o1, o2;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  adc_sample_conditioner #(.DEC_LOG2(0), .ADC_INV(1'b0)) u0 (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .en_i(en), .adc_dat_i(p_dat), .adc_vld_i(p_vld),
`ifdef ADC_COND_OFFSET_EN
    .offset_i(off),
`endif
    .m_dat_o(d0), .m_vld_o(v0), .m_rdy_i(p_rdy), .ovr_o(o0), .ovr_clr_i(ovr_clr), .drop_cnt_o(c0));
  adc_sample_conditioner #(.DEC_LOG2(0), .ADC_INV(1'b1)) u1 (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .en_i(en), .adc_dat_i(p_dat), .adc_vld_i(p_vld),
`ifdef ADC_COND_OFFSET_EN
    .offset_i(14'h0000),
`endif
    .m_dat_o(d1), .m_vld_o(v1), .m_rdy_i(p_rdy), .ovr_o(o1), .ovr_clr_i(ovr_clr), .drop_cnt_o(c1));
  adc_sample_conditioner #(.DEC_LOG2(2), .ADC_INV(1'b0)) u2 (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .en_i(en), .adc_dat_i(dat), .adc_vld_i(vld),
`ifdef ADC_COND_OFFSET_EN
    .offset_i(14'h0000),
`endif
    .m_dat_o(d2), .m_vld_o(v2), .m_rdy_i(rdy), .ovr_o(o2), .ovr_clr_i(ovr_clr), .drop_cnt_o(c2));

  typedef struct { logic [13:0] raw; logic [15:0] e0; logic [15:0] e1; } pt_t;
  typedef struct { logic [3:0][13:0] raw; logic gap; logic [15:0] exp; } blk_t;
  pt_t  pt[5];
  blk_t bt[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive four samples into u2; returns one cycle after the last is captured
  task automatic send4(input logic [3:0][13:0] r, input logic gap);
    for (int i = 0; i < 4; i++) begin
      dat = r[i];
      vld = 1'b1;
      tick();
      vld = 1'b0;
      if (gap && i < 3) tick();
    end
  endtask

  task automatic pass1(input logic [13:0] raw, input logic [15:0] e0, input string nm);
    p_dat = raw;
    p_vld = 1'b1;
    tick();
    p_vld = 1'b0;
    tick();
    chk({nm, " vld"}, 32'(v0), 32'd1);
    chk({nm, " dat"}, 32'(d0), 32'(e0));
    tick();
  endtask

  initial begin
    pt[0] = '{14'h2123, 16'h048C, 16'hFB70};
    pt[1] = '{14'h0000, 16'h8000, 16'h7FFC};
    pt[2] = '{14'h3FFF, 16'h7FFC, 16'h8000};
    pt[3] = '{14'h2000, 16'h0000, 16'hFFFC};
    pt[4] = '{14'h1FFF, 16'hFFFC, 16'h0000};
    bt[0] = '{{14'h2005, 14'h2003, 14'h2002, 14'h2001}, 1'b0, 16'h000C};
    bt[1] = '{{14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF}, 1'b0, 16'hFFFC};
    bt[2] = '{{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF}, 1'b1, 16'h7FFC};
    bt[3] = '{{14'h0000, 14'h0000, 14'h0000, 14'h0000}, 1'b0, 16'h8000};
    bt[4] = '{{14'h2000, 14'h2000, 14'h2000, 14'h2001}, 1'b1, 16'h0000};
    bt[5] = '{{14'h2000, 14'h2000, 14'h2000, 14'h2002}, 1'b0, 16'h0004};
    bt[6] = '{{14'h2000, 14'h2000, 14'h2000, 14'h1FFE}, 1'b1, 16'h0000};
    bt[7] = '{{14'h2000, 14'h2000, 14'h2000, 14'h1FFD}, 1'b0, 16'hFFFC};

    tick();
    chk("rst u2 dat", 32'(d2), 32'h0);
    chk("rst u2 vld", 32'(v2), 32'h0);
    chk("rst u2 ovr", 32'(o2), 32'h0);
    chk("rst u2 drop", 32'(c2), 32'h0);
    chk("rst u0 vld", 32'(v0), 32'h0);
    rstn = 1'b1;
    en = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 5; i++) begin
      p_dat = pt[i].raw;
      p_vld = 1'b1;
      tick();
      p_vld = 1'b0;
      chk($sformatf("pt%0d lat", i), 32'(v0), 32'd0);
      tick();
      chk($sformatf("pt%0d vld", i), 32'(v0), 32'd1);
      chk($sformatf("pt%0d inv0", i), 32'(d0), 32'(pt[i].e0));
      chk($sformatf("pt%0d inv1", i), 32'(d1), 32'(pt[i].e1));
      tick();
    end

    for (int i = 0; i < 8; i++) begin
      send4(bt[i].raw, bt[i].gap);
      chk($sformatf("blk%0d lat", i), 32'(v2), 32'd0);
      tick();
      chk($sformatf("blk%0d vld", i), 32'(v2), 32'd1);
      chk($sformatf("blk%0d dat", i), 32'(d2), 32'(bt[i].exp));
      tick();
      chk($sformatf("blk%0d done", i), 32'(v2), 32'd0);
    end

    rdy = 1'b0;
    send4(bt[5].raw, 1'b0);
    tick();
    chk("hold first", 32'(d2), 32'h0004);
    chk("hold ovr0", 32'(o2), 32'd0);
    send4(bt[1].raw, 1'b0);
    tick();
    chk("drop1 cnt", 32'(c2), 32'd1);
    chk("drop1 ovr", 32'(o2), 32'd1);
    send4(bt[1].raw, 1'b0);
    tick();
    chk("drop2 cnt", 32'(c2), 32'd2);
    chk("drop2 dat", 32'(d2), 32'h0004);
    chk("drop2 vld", 32'(v2), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr cnt", 32'(c2), 32'd0);
    chk("clr ovr", 32'(o2), 32'd0);
    send4(bt[1].raw, 1'b0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr+drop cnt", 32'(c2), 32'd1);
    chk("clr+drop ovr", 32'(o2), 32'd1);
    chk("clr+drop dat", 32'(d2), 32'h0004);
    rdy = 1'b1;
    tick();
    chk("drain vld", 32'(v2), 32'd0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;

    for (int i = 0; i < 3; i++) begin
      dat = 14'h3FFF;
      vld = 1'b1;
      tick();
      vld = 1'b0;
    end
    en = 1'b0;
    tick();
    tick();
    chk("partial none", 32'(v2), 32'd0);
    en = 1'b1;
    tick();
    send4(bt[5].raw, 1'b0);
    chk("reen lat", 32'(v2), 32'd0);
    tick();
    chk("reen vld", 32'(v2), 32'd1);
    chk("reen dat", 32'(d2), 32'h0004);
    tick();
    tick();
    chk("reen single", 32'(v2), 32'd0);

    rdy = 1'b0;
    send4(bt[1].raw, 1'b0);
    tick();
    dat = 14'h3FFF;
    vld = 1'b1;
    tick();
    tick();
    vld = 1'b0;
    ovr_clr = 1'b0;
    send4(bt[1].raw, 1'b0);
    tick();
    chk("pre-rst vld", 32'(v2), 32'd1);
    chk("pre-rst ovr", 32'(o2), 32'd1);
    dat = 14'h3FFF;
    vld = 1'b1;
    tick();
    tick();
    vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst dat", 32'(d2), 32'h0);
    chk("arst vld", 32'(v2), 32'h0);
    chk("arst ovr", 32'(o2), 32'h0);
    chk("arst drop", 32'(c2), 32'h0);
    tick();
    rstn = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    send4(bt[0].raw, 1'b0);
    tick();
    chk("post-rst vld", 32'(v2), 32'd1);
    chk("post-rst dat", 32'(d2), 32'h000C);
    tick();

`ifdef ADC_COND_OFFSET_EN
    off = 14'h0100;
    pass1(14'h2123, 16'h008C, "off sub");
    off = 14'h2000;
    pass1(14'h3FFF, 16'h7FFC, "off clamp hi");
    off = 14'h1FFF;
    pass1(14'h0000, 16'h8000, "off clamp lo");
    off = 14'h0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
